// File: rtl/ad4003_frame_packer_if.sv
// ---------------------------------------------------------------------------
// ad4003_frame_packer_if
//   32-bit AXI4-Stream master channel used by ad4003_frame_packer to hand
//   packed ADC frames to the DMA path.
//
//   Signals:
//     m_axis_tdata   32  stream data        (master -> slave)
//     m_axis_tvalid   1  stream valid       (master -> slave)
//     m_axis_tlast    1  last word of packet (master -> slave)
//     m_axis_tready   1  stream ready       (slave  -> master)
//
//   Modports:
//     master  the frame packer side
//     slave   the DMA / sink side
// ---------------------------------------------------------------------------
interface ad4003_frame_packer_if;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/ad4003_frame_packer.sv
// ---------------------------------------------------------------------------
// ad4003_frame_packer
//   Downstream stage of the AD4003 deserializer. Each sample_valid pulse
//   (with enable high) snapshots a full frame of ADC_CHANNELS 18-bit samples
//   into a pending slot. Frames are moved from pending into an active slot
//   and emitted as one AXI4-Stream packet:
//     word 0      : {HDR_MAGIC, ADC_CHANNELS[7:0], frame_tag[15:0]}
//     word 1..N   : {ch_idx[5:0], 8'h00, sample[ch_idx]}  (tlast on word N)
//   When both slots are occupied a new frame is dropped and counted.
//
//   Ports:
//     clk           single clock for all logic
//     rst_n         synchronous active-low reset
//     enable        frame acceptance enable
//     sample_valid  one-cycle pulse, adc_data_arr holds a complete frame
//     adc_data_arr  packed samples, channel c at [18c +: 18]
//     m_axis        AXI4-Stream master (tdata/tvalid/tlast out, tready in)
//     frame_cnt     accepted-frame counter (wraps)
//     overflow_cnt  dropped-frame counter (saturates)
//     busy          high while a packet is in flight or pending slot full
// ---------------------------------------------------------------------------
module ad4003_frame_packer #(
    parameter int          ADC_CHANNELS   = 8,
    parameter int          ADC_DATA_WIDTH = 18,
    parameter logic [7:0]  HDR_MAGIC      = 8'hA5
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   enable,
    input  logic                                   sample_valid,
    input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
    ad4003_frame_packer_if.master                  m_axis,
    output logic [15:0]                            frame_cnt,
    output logic [15:0]                            overflow_cnt,
    output logic                                   busy
);

    localparam int         FRAME_W = ADC_DATA_WIDTH * ADC_CHANNELS;
    localparam logic [7:0] CH_BYTE = 8'(ADC_CHANNELS);
    localparam logic [5:0] CH_LAST = 6'(ADC_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           ch_idx_q, ch_idx_d;

    logic                 pend_full_q, pend_full_d;
    logic [FRAME_W-1:0]   pend_data_q, pend_data_d;
    logic [15:0]          pend_tag_q, pend_tag_d;

    logic [FRAME_W-1:0]   act_data_q, act_data_d;
    logic [15:0]          act_tag_q, act_tag_d;

    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [15:0]          ovf_cnt_q, ovf_cnt_d;

    logic                         tvalid_w;
    logic                         handshake;
    logic                         last_word;
    logic                         move;
    logic                         frame_in;
    logic                         capture;
    logic                         drop;
    logic [ADC_DATA_WIDTH-1:0]    cur_sample;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_idx_q    <= '0;
            pend_full_q <= 1'b0;
            pend_data_q <= '0;
            pend_tag_q  <= '0;
            act_data_q  <= '0;
            act_tag_q   <= '0;
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            pend_tag_q  <= pend_tag_d;
            act_data_q  <= act_data_d;
            act_tag_q   <= act_tag_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample mux for the current data word
    // ------------------------------------------------------------------
    always_comb begin
        cur_sample = '0;
        for (int unsigned c = 0; c < ADC_CHANNELS; c++) begin
            if (ch_idx_q == 6'(c)) begin
                cur_sample = act_data_q[c*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state, slot management and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        pend_tag_d  = pend_tag_q;
        act_data_d  = act_data_q;
        act_tag_d   = act_tag_q;
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;

        // tvalid depends only on registered state, never on tready.
        tvalid_w  = (state_q != IDLE);
        handshake = tvalid_w && m_axis.m_axis_tready;
        last_word = (state_q == DATA) && (ch_idx_q == CH_LAST);

        // Pending -> active transfer: either starting from idle, or chaining
        // straight into the next header on the last-word handshake.
        move = pend_full_q &&
               ((state_q == IDLE) || (handshake && last_word));

        // A move frees the pending slot in the same edge, so a frame arriving
        // on that edge is still accepted.
        frame_in = sample_valid && enable;
        capture  = frame_in && (!pend_full_q || move);
        drop     = frame_in && pend_full_q && !move;

        case (state_q)
            IDLE: begin
                if (move) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (handshake) begin
                    state_d  = DATA;
                    ch_idx_d = '0;
                end
            end
            DATA: begin
                if (handshake) begin
                    if (!last_word) begin
                        ch_idx_d = ch_idx_q + 6'd1;
                    end else if (move) begin
                        state_d = HEADER;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (move) begin
            act_data_d  = pend_data_q;
            act_tag_d   = pend_tag_q;
            pend_full_d = 1'b0;
        end

        if (capture) begin
            pend_full_d = 1'b1;
            pend_data_d = adc_data_arr;
            pend_tag_d  = frame_cnt_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state, so stable while stalled
    // ------------------------------------------------------------------
    always_comb begin
        m_axis.m_axis_tvalid = tvalid_w;
        m_axis.m_axis_tlast  = last_word;
        case (state_q)
            HEADER:  m_axis.m_axis_tdata = {HDR_MAGIC, CH_BYTE, act_tag_q};
            DATA:    m_axis.m_axis_tdata = {ch_idx_q, 8'h00, cur_sample};
            default: m_axis.m_axis_tdata = '0;
        endcase
    end

    assign frame_cnt    = frame_cnt_q;
    assign overflow_cnt = ovf_cnt_q;
    assign busy         = (state_q != IDLE) || pend_full_q;

endmodule

// File: tb/tb_ad4003_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_ad4003_frame_packer
//   Directed testbench for ad4003_frame_packer. A packet-level model keeps a
//   pending-frame slot and a queue of words still owed on the stream; a
//   negedge compare process checks every output against it each cycle.
//   Directed sequences add literal expectations on the logged stream.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ad4003_frame_packer;

    localparam int CH = 8;
    localparam int DW = 18;
    localparam int FW = CH * DW;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          sample_valid;
    logic [FW-1:0] adc_data_arr;
    logic [15:0]   frame_cnt;
    logic [15:0]   overflow_cnt;
    logic          busy;

    ad4003_frame_packer_if axis ();

    ad4003_frame_packer #(
        .ADC_CHANNELS   (CH),
        .ADC_DATA_WIDTH (DW),
        .HDR_MAGIC      (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .adc_data_arr (adc_data_arr),
        .m_axis       (axis),
        .frame_cnt    (frame_cnt),
        .overflow_cnt (overflow_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    logic [31:0]   out_q[$];
    bit            m_pend;
    logic [FW-1:0] m_pdata;
    logic [15:0]   m_ptag;
    logic [15:0]   m_fc;
    logic [15:0]   m_ovf;
    bit            model_live = 0;

    task automatic emit_packet(input logic [FW-1:0] d, input logic [15:0] tag);
        out_q.push_back({8'hA5, 8'(CH), tag});
        for (int c = 0; c < CH; c++) begin
            out_q.push_back({6'(c), 8'h00, d[c*DW +: DW]});
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            out_q.delete();
            m_pend     = 0;
            m_fc       = '0;
            m_ovf      = '0;
            model_live = 1;
        end else if (model_live) begin
            if (out_q.size() > 0 && axis.m_axis_tready) void'(out_q.pop_front());
            if (out_q.size() == 0 && m_pend) begin
                emit_packet(m_pdata, m_ptag);
                m_pend = 0;
            end
            if (sample_valid && enable) begin
                if (!m_pend) begin
                    m_pend  = 1;
                    m_pdata = adc_data_arr;
                    m_ptag  = m_fc;
                    m_fc    = m_fc + 16'd1;
                end else if (m_ovf != 16'hFFFF) begin
                    m_ovf = m_ovf + 16'd1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live && rst_n) begin
            check("tvalid", 32'(axis.m_axis_tvalid), 32'(out_q.size() > 0));
            if (out_q.size() > 0) begin
                check("tdata", axis.m_axis_tdata, out_q[0]);
                check("tlast", 32'(axis.m_axis_tlast), 32'(out_q.size() == 1));
            end
            check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
            check("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
            check("busy", 32'(busy), 32'((out_q.size() > 0) || m_pend));
        end
    end

    // ---------------- handshake log ----------------
    logic [31:0] log_d[$];
    bit          log_l[$];

    always @(negedge clk) begin
        if (rst_n && axis.m_axis_tvalid && axis.m_axis_tready) begin
            log_d.push_back(axis.m_axis_tdata);
            log_l.push_back(axis.m_axis_tlast);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [FW-1:0] mkframe(input logic [17:0] base);
        logic [FW-1:0] f;
        for (int c = 0; c < CH; c++) f[c*DW +: DW] = base + 18'(c);
        return f;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_d.delete();
        log_l.delete();
    endtask

    task automatic pulse(input logic [17:0] base);
        @(posedge clk);
        #1;
        adc_data_arr = mkframe(base);
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while (log_d.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(log_d.size()), 32'(n));
    endtask

    initial begin
        bit found;
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        adc_data_arr = '0;
        axis.m_axis_tready = 1'b0;

        // ---- 1: single frame, tready=1 ----
        do_reset();
        check("reset_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
        check("reset_tdata", axis.m_axis_tdata, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        axis.m_axis_tready = 1'b1;
        pulse(18'h20000);
        wait_log(9, 40, "t1_words");
        repeat (3) @(posedge clk);
        #1;
        check("t1_count_exact", 32'(log_d.size()), 32'd9);
        if (log_d.size() >= 9) begin
            check("t1_header", log_d[0], 32'hA5080000);
            check("t1_word1", log_d[1], 32'h00020000);
            check("t1_word8", log_d[8], 32'h1C020007);
            for (int i = 0; i < 9; i++) check("t1_tlast", 32'(log_l[i]), 32'(i == 8));
        end
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

        // ---- 2: random tready over 3 frames ----
        do_reset();
        fork
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1;
                    axis.m_axis_tready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                pulse(18'h01000);
                repeat (30) @(posedge clk);
                pulse(18'h02000);
                repeat (30) @(posedge clk);
                pulse(18'h03000);
            end
        join
        axis.m_axis_tready = 1'b1;
        wait_log(27, 100, "t2_words");
        if (log_d.size() >= 27) begin
            check("t2_tag0", log_d[0], 32'hA5080000);
            check("t2_tag1", log_d[9], 32'hA5080001);
            check("t2_tag2", log_d[18], 32'hA5080002);
        end
        check("t2_overflow", 32'(overflow_cnt), 32'd0);

        // ---- 3: backpressure, third frame dropped ----
        do_reset();
        axis.m_axis_tready = 1'b0;
        pulse(18'h10000);
        repeat (10) @(posedge clk);
        pulse(18'h11000);
        repeat (10) @(posedge clk);
        pulse(18'h12000);
        check("t3_overflow", 32'(overflow_cnt), 32'd1);
        check("t3_frame_cnt", 32'(frame_cnt), 32'd2);
        check("t3_busy", 32'(busy), 32'd1);
        axis.m_axis_tready = 1'b1;
        wait_log(18, 60, "t3_words");
        repeat (5) @(posedge clk);
        #1;
        check("t3_count_exact", 32'(log_d.size()), 32'd18);
        if (log_d.size() >= 18) begin
            check("t3_tag0", log_d[0], 32'hA5080000);
            check("t3_tag1", log_d[9], 32'hA5080001);
            check("t3_data_f1", log_d[10], 32'h00011000);
        end

        // ---- 4: capture on the chaining last-word edge ----
        do_reset();
        axis.m_axis_tready = 1'b1;
        pulse(18'h04000);
        pulse(18'h05000);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #1;
            if (axis.m_axis_tvalid && axis.m_axis_tlast) found = 1;
        end
        check("t4_found_last", 32'(found), 32'd1);
        adc_data_arr = mkframe(18'h06000);
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        check("t4_no_bubble_tvalid", 32'(axis.m_axis_tvalid), 32'd1);
        check("t4_no_bubble_header", axis.m_axis_tdata, 32'hA5080001);
        check("t4_overflow", 32'(overflow_cnt), 32'd0);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd3);
        wait_log(27, 60, "t4_words");
        if (log_d.size() >= 27) check("t4_tag2", log_d[18], 32'hA5080002);

        // ---- 5: enable low ignores pulses ----
        do_reset();
        enable = 1'b0;
        repeat (5) begin
            pulse(18'h07000);
            repeat (3) @(posedge clk);
        end
        repeat (5) @(posedge clk);
        #1;
        check("t5_words", 32'(log_d.size()), 32'd0);
        check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t5_overflow", 32'(overflow_cnt), 32'd0);
        check("t5_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
        enable = 1'b1;

        // ---- 6: reset mid-DATA then fresh packet ----
        do_reset();
        axis.m_axis_tready = 1'b1;
        pulse(18'h08000);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #1;
            if (axis.m_axis_tvalid && axis.m_axis_tdata[31:24] != 8'hA5 &&
                axis.m_axis_tdata[31:26] == 6'd3) found = 1;
        end
        check("t6_found_ch3", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
        check("t6_tdata", axis.m_axis_tdata, 32'd0);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t6_overflow", 32'(overflow_cnt), 32'd0);
        rst_n = 1'b1;
        log_d.delete();
        log_l.delete();
        pulse(18'h00100);
        wait_log(9, 40, "t6_words");
        if (log_d.size() >= 9) begin
            check("t6_header", log_d[0], 32'hA5080000);
            check("t6_word_ch2", log_d[3], 32'h08000102);
            check("t6_tlast", 32'(log_l[8]), 32'd1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
